// File: rtl/mini_alu_16bit_mul_acc.sv
// ---------------------------------------------------------------------------
// mini_alu_16bit_mul_acc
//   Multiply-accumulate back end for the 16-bit multiplier. It sums a burst of
//   BURST_LEN unsigned 32-bit products into an ACC_W-bit accumulator, tracks a
//   sticky overflow for the burst, and presents the result to the next ALU
//   stage on a valid/ready handshake.
//
//   Build option:
//     MINI_ALU_MUL_ACC_SATURATE_EN  defined   -> accumulator clamps to all-ones
//                                                 on carry-out
//                                   undefined -> accumulator wraps modulo 2^ACC_W
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   product beat valid
//     product    in   [31:0] unsigned product from the multiplier
//     mul_ovf    in   multiplier overflow for this beat
//     in_ready   out  beat can be accepted (IDLE/ACCUM)
//     clear      in   synchronous abort, discards the burst
//     acc_out    out  [ACC_W-1:0] accumulated sum (registered)
//     acc_valid  out  acc_out is valid (DONE)
//     acc_ovf    out  sticky overflow for the burst
//     out_ready  in   consumer accepts acc_out
//     beat_cnt   out  [CNT_W-1:0] beats accepted in the current burst
// ---------------------------------------------------------------------------
module mini_alu_16bit_mul_acc #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      product,
    input  logic             mul_ovf,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic             acc_ovf,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic [ACC_W:0]   sum_d;
    logic             carry_d;
    logic [ACC_W-1:0] acc_add_d;
    logic [CNT_W-1:0] cnt_inc_d;

    // Decoded from registered state only: no combinational path from in_valid.
    assign in_ready = (state_q != DONE);
    assign accept   = in_valid & in_ready;

    // One extra bit captures the carry-out used for overflow detection.
    assign sum_d     = {1'b0, acc_q} + (ACC_W+1)'(product);
    assign carry_d   = sum_d[ACC_W];
    assign cnt_inc_d = cnt_q + CNT_W'(1);

`ifdef MINI_ALU_MUL_ACC_SATURATE_EN
    // Once clamped, any later non-zero product carries again, so the value
    // stays at all-ones for the rest of the burst without extra state.
    assign acc_add_d = carry_d ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
`else
    assign acc_add_d = sum_d[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (clear) begin
            // Abort wins over everything, including a beat or a handshake
            // presented in the same cycle.
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q <= ACC_W'(product);
                        ovf_q <= mul_ovf;
                        cnt_q <= CNT_W'(1);
                        if (BURST_LEN == 1) begin
                            state_q <= DONE;
                            vld_q   <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_add_d;
                        ovf_q <= ovf_q | mul_ovf | carry_d;
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == LAST_CNT) begin
                            state_q <= DONE;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result frozen until the consumer takes it; returning to
                    // IDLE wipes the burst state for the next one.
                    if (out_ready) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign acc_out   = acc_q;
    assign acc_ovf   = ovf_q;
    assign acc_valid = vld_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: doc/mini_alu_16bit_mul_acc.md
Name: mini_alu_16bit_mul_acc

Overview:
- Downstream stage of the 16-bit multiplier. Consumes its 32-bit product, overflow flag and valid flag.
- Accumulates a burst of BURST_LEN products into an ACC_W-bit register.
- Presents the sum, with a sticky overflow flag, on a valid/ready output handshake.
- Converts the multiplier's combinational result stream into a registered, flow-controlled MAC result for the next ALU stage.

Parameters:
- BURST_LEN, 4, products per accumulation; legal range 1..255.
- ACC_W, 32, accumulator width; must be >= 32.
- CNT_W, 8, beat counter width; must hold BURST_LEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product beat valid (driven from the multiplier's valid)
- product  input  32  unsigned product from the multiplier
- mul_ovf  input  1  multiplier overflow flag for this beat
- in_ready  output  1  stage can accept a beat
- clear  input  1  synchronous abort; discards the burst
- acc_out  output  ACC_W  accumulated sum, registered
- acc_valid  output  1  acc_out is valid
- acc_ovf  output  1  sticky overflow for the presented burst
- out_ready  input  1  consumer accepts acc_out
- beat_cnt  output  CNT_W  beats accepted in the current burst

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE
  - acc_out=0, acc_valid=0, acc_ovf=0, beat_cnt=0, in_ready=1
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready is 1 in IDLE and ACCUM and 0 in DONE. It is a combinational decode of the registered state only, so there is no path from in_valid.
- IDLE:
  - acc_out=0, acc_ovf=0, beat_cnt=0.
  - On an accepted beat: acc_out=zero-extended product, acc_ovf=mul_ovf, beat_cnt=1.
  - Next state is DONE if BURST_LEN==1, else ACCUM.
- ACCUM, on each accepted beat:
  - acc_out = acc_out + product, computed at ACC_W+1 bits.
  - acc_ovf |= mul_ovf | carry-out(bit ACC_W).
  - beat_cnt++.
  - The beat that makes beat_cnt==BURST_LEN moves the state to DONE.
  - Idle cycles (in_valid=0) hold all state.
- DONE:
  - acc_valid=1. acc_out, acc_ovf and beat_cnt are frozen. in_valid is ignored.
  - out_ready=1 completes the transfer. The next cycle is IDLE with acc_valid=0, acc_out=0, acc_ovf=0, beat_cnt=0.
- Latency: acc_valid rises in the first cycle after the edge that accepts the final beat. Minimum inter-burst gap is one IDLE cycle after the handshake.
- Arithmetic:
  - Unsigned only. product is zero-extended to ACC_W.
  - Without saturation, the sum wraps modulo 2^ACC_W.
- clear:
  - Highest synchronous priority, in any state.
  - Next state is IDLE with all outputs at reset values.
  - A beat presented in the same cycle as clear is dropped.
  - In DONE, clear discards the result even if out_ready=1; no transfer is counted.
- Reset mid-operation: the burst is lost immediately. There is no partial result.
- acc_ovf is sticky per burst. It is cleared only on IDLE entry, clear, or reset.

Optional Feature:
- Macro: MINI_ALU_MUL_ACC_SATURATE_EN.
- Defined: on carry-out the accumulator clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the burst. acc_ovf is still set.
- Undefined: wrap-around as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Four beats 10,20,30,40 back-to-back, out_ready=1 -> acc_out=100, acc_ovf=0, acc_valid high exactly 1 cycle after 4th beat, beat_cnt=4, then IDLE.
- Same burst with out_ready=0 for 5 cycles while in_valid pulses -> acc_out holds 100, in_ready=0, no beat counted; raising out_ready -> IDLE next cycle, in_ready=1.
- Four beats of 0xFFFE0001 (65535*65535):
  - Default build -> acc_out=0xFFF80004, acc_ovf=1.
  - MINI_ALU_MUL_ACC_SATURATE_EN build -> acc_out=0xFFFFFFFF, acc_ovf=1.
- Beats 1,2,3,4 with mul_ovf=1 on the 2nd beat only -> acc_out=10, acc_ovf=1; the next burst of 1,1,1,1 -> acc_out=4, acc_ovf=0.
- clear after 2 beats of 7, then 4 beats of 5 -> first partial burst discarded, beat_cnt=0 after clear, final acc_out=20.
- rst_n pulsed low mid-cycle during ACCUM with beat_cnt=3 -> outputs zero immediately without a clock edge. After release, 4 beats of 2 -> acc_out=8.
